// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling and a runtime-selectable baud rate (8N1).
// Define UART_RX_PARITY_EN to expect one even-parity bit after the eight data bits.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 18_432_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_bussy,
  output logic       rx_tick
);

  localparam int unsigned DIV_9600   = CLK_FREQ / (16 * 9600);
  localparam int unsigned DIV_19200  = CLK_FREQ / (16 * 19200);
  localparam int unsigned DIV_57600  = CLK_FREQ / (16 * 57600);
  localparam int unsigned DIV_115200 = CLK_FREQ / (16 * 115200);
  localparam int unsigned CNT_W      = $clog2(DIV_9600 + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             line_s;
  logic [1:0]       baud_q;
  logic [CNT_W-1:0] div_m1_c;
  logic [CNT_W-1:0] tcnt_q, tcnt_nxt_c;
  logic [3:0]       scnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             valid_c, error_c, par_fault_c;

  // Two-flop synchronizer; the line idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx_in};
  end
  assign line_s = sync_q[1];

  // Baud selection only follows baud_sel between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    baud_q <= 2'b00;
    else if (state_q == S_IDLE)  baud_q <= baud_sel;
  end

  always_comb begin
    div_m1_c = CNT_W'(DIV_9600 - 1);
    case (baud_q)
      2'b00:   div_m1_c = CNT_W'(DIV_9600 - 1);
      2'b01:   div_m1_c = CNT_W'(DIV_19200 - 1);
      2'b10:   div_m1_c = CNT_W'(DIV_57600 - 1);
      default: div_m1_c = CNT_W'(DIV_115200 - 1);
    endcase
  end

  // Free-running tick counter; >= guards against a divisor shrinking mid-count.
  assign tcnt_nxt_c = (tcnt_q >= div_m1_c) ? '0 : tcnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q  <= '0;
      rx_tick <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_nxt_c;
      rx_tick <= (tcnt_nxt_c == div_m1_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_tick) begin
      case (state_q)
        S_IDLE:      if (!line_s) state_d = S_START;
        S_START:     if (scnt_q == 4'd7) state_d = line_s ? S_IDLE : S_DATA;
        S_DATA: begin
          if (scnt_q == 4'd15 && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY:    if (scnt_q == 4'd15) state_d = S_STOP;
`endif
        S_STOP:      if (scnt_q == 4'd15) state_d = line_s ? S_IDLE : S_WAIT_IDLE;
        S_WAIT_IDLE: if (line_s) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Frame verdict is taken at the middle of the stop bit.
  always_comb begin
    valid_c = 1'b0;
    error_c = 1'b0;
    if (rx_tick && state_q == S_STOP && scnt_q == 4'd15) begin
      if (!line_s || par_fault_c) error_c = 1'b1;
      else                        valid_c = 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                       par_err_q <= 1'b0;
    else if (rx_tick && state_q == S_IDLE)                          par_err_q <= 1'b0;
    else if (rx_tick && state_q == S_PARITY && scnt_q == 4'd15)     par_err_q <= ^{shift_q, line_s};
  end
  assign par_fault_c = par_err_q;
`else
  assign par_fault_c = 1'b0;
`endif

  // Sample counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (rx_tick) begin
      case (state_q)
        S_START: begin
          scnt_q <= (scnt_q == 4'd7) ? 4'd0 : scnt_q + 4'd1;
          bit_q  <= '0;
        end
        S_DATA: begin
          scnt_q <= scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shift_q <= {line_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: scnt_q <= scnt_q + 4'd1;
`endif
        S_STOP:   scnt_q <= scnt_q + 4'd1;
        default:  scnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      rx_bussy <= 1'b0;
    end else begin
      rx_valid <= valid_c;
      rx_error <= error_c;
      rx_bussy <= (state_d != S_IDLE);
      if (valid_c) rx_byte <= shift_q;
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 18_432_000, system clock frequency in Hz.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 baud_sel  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-005 rx_in  input  1  asynchronous serial line, idle high.
REQ-006 rx_byte  output  8  last correctly received byte.
REQ-007 rx_valid  output  1  one-cycle pulse: rx_byte updated.
REQ-008 rx_error  output  1  one-cycle pulse: frame rejected.
REQ-009 rx_bussy  output  1  high while a frame is in progress.
REQ-010 rx_tick  output  1  one-cycle 16x-oversample tick.

Function
REQ-011 rx_in SHALL pass a 2-flop synchronizer; all logic uses the synchronized value.
REQ-012 Divisor DIV SHALL be CLK_FREQ/(16*baud), integer truncation; default values are 120/60/20/10.
REQ-013 The tick counter SHALL count 0..DIV-1 free-running and assert rx_tick for the cycle in which it equals DIV-1.
REQ-014 baud_sel SHALL be latched only in IDLE; changes during a frame SHALL be ignored until return to IDLE.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; transitions occur only on rx_tick.
REQ-016 IDLE: synchronized line 0 on a tick -> START, sample counter cleared.
REQ-017 START: on 8th tick, line 0 -> DATA (bit index 0, sample counter cleared); line 1 -> IDLE, false start, no error pulse.
REQ-018 DATA: every 16th tick sample one bit, LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-019 STOP: on 16th tick, line 1 and no pending parity fault -> rx_byte loaded, rx_valid pulsed, -> IDLE.
REQ-020 STOP: line 0 -> rx_error pulsed, rx_byte unchanged, -> WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until a tick samples line 1, then -> IDLE; break conditions yield exactly one rx_error.
REQ-022 rx_valid/rx_error SHALL assert the cycle after the deciding tick, for exactly one cycle, never together.
REQ-023 rx_bussy SHALL be 1 in every state except IDLE.
REQ-024 Back-to-back frames (new start bit immediately after stop) SHALL be received without loss.

Reset
REQ-025 On rst low: state IDLE, synchronizer flops 1, all counters 0, rx_byte 8'h00, rx_valid 0, rx_error 0, rx_bussy 0, rx_tick 0, latched baud from baud_sel after release.
REQ-026 Reset mid-frame SHALL discard the frame with no rx_valid or rx_error after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after bit 7; mismatch -> rx_error at STOP (rx_byte unchanged), stop-bit checks still apply.
REQ-028 UART_RX_PARITY_EN undefined: 8N1 framing, PARITY state and logic absent, DATA -> STOP directly.

Verification
REQ-029 baud_sel=11, send 8'hA5 8N1 -> rx_valid one pulse, rx_byte=8'hA5, rx_bussy high ~1600 clk cycles, rx_tick every 10 clk.
REQ-030 baud_sel=00, send 8'h3C then 8'hC3 back-to-back -> two rx_valid pulses, values 3C then C3, rx_tick period 120 clk.
REQ-031 Stop bit forced 0 on 8'h55 -> one rx_error pulse, no rx_valid, rx_byte keeps prior value; line held low 3 frame times -> still exactly one rx_error.
REQ-032 Low glitch of 3 ticks on idle line -> IDLE regained, no rx_valid/rx_error, rx_bussy drops after START.
REQ-033 rst asserted mid-DATA of 8'hFF, released, then 8'h12 sent -> only rx_valid with rx_byte=8'h12.
REQ-034 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> rx_error; with parity bit 1 -> rx_valid, rx_byte=8'h07.
